// File: rtl/mips_mem_arbiter_if.sv
// Bundle of the two requester ports and the single-ported memory bus that
// the arbiter sits between. The arbiter uses the master view; the
// environment (CPU ports plus memory slave) drives the other side.
interface mips_mem_arbiter_if;
  // instruction-fetch requester
  logic        i_read;
  logic [31:0] i_address;
  logic [31:0] i_readdata;
  logic        i_ack;
  // data requester
  logic        d_read;
  logic        d_write;
  logic [31:0] d_address;
  logic [31:0] d_writedata;
  logic [3:0]  d_byteenable;
  logic [31:0] d_readdata;
  logic        d_ack;
  // shared memory bus
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        bus_error;

  modport master (
    input  i_read, i_address, d_read, d_write, d_address, d_writedata,
           d_byteenable, waitrequest, readdata,
    output i_readdata, i_ack, d_readdata, d_ack, address, read, write,
           writedata, byteenable, bus_error
  );

  modport slave (
    output i_read, i_address, d_read, d_write, d_address, d_writedata,
           d_byteenable, waitrequest, readdata,
    input  i_readdata, i_ack, d_readdata, d_ack, address, read, write,
           writedata, byteenable, bus_error
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one wait-request memory bus between the
// instruction-fetch and data ports of the MIPS CPU. Every output is a flop;
// a transaction takes at least two cycles (strobe cycle, then ack cycle).
// An optional watchdog aborts a transaction stuck on waitrequest.
module mips_mem_arbiter #(
  parameter int unsigned MAX_WAIT = 32'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  mips_mem_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] i_readdata_q, i_readdata_d;
  logic        i_ack_q, i_ack_d;
  logic [31:0] d_readdata_q, d_readdata_d;
  logic        d_ack_q, d_ack_d;
  logic        bus_error_q, bus_error_d;

  logic        i_elig;
  logic        d_elig;
  logic        grant_i;
  logic        grant_d;
  logic        busy;
  logic        complete;
  logic        timeout;
  logic [31:0] wait_inc;

  // Qualify requests (a port being acked this cycle is masked), pick the winner, decode end of transfer
  always_comb begin
    i_elig   = bus.i_read & ~i_ack_q;
    d_elig   = (bus.d_read | bus.d_write) & ~d_ack_q;
    busy     = (state_q != IDLE) & (read_q | write_q);
    wait_inc = wait_cnt_q + 32'd1;
    complete = busy & ~bus.waitrequest;
    timeout  = busy & bus.waitrequest & (MAX_WAIT != 32'd0) & (wait_inc >= MAX_WAIT);
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE) begin
      if (i_elig && (!d_elig || (last_grant_q == GRANT_D))) begin
        grant_i = 1'b1;
      end else if (d_elig) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b0;
        grant_d = 1'b0;
      end
    end else begin
      grant_i = 1'b0;
      grant_d = 1'b0;
    end
  end

  // Next-state logic for the transaction FSM and the round-robin pointer
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = BUSY_I;
          last_grant_d = GRANT_I;
        end else if (grant_d) begin
          state_d      = BUSY_D;
          last_grant_d = GRANT_D;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (complete || timeout) begin
          state_d = IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered bus strobes, acks, read data, watchdog and error flag
  always_comb begin
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    i_readdata_d = i_readdata_q;
    d_readdata_d = d_readdata_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    bus_error_d  = bus_error_q;
    wait_cnt_d   = wait_cnt_q;
    if (grant_i) begin
      address_d    = {bus.i_address[31:2], 2'b00};
      read_d       = 1'b1;
      write_d      = 1'b0;
      byteenable_d = 4'b1111;
      wait_cnt_d   = 32'd0;
    end else if (grant_d) begin
      address_d    = {bus.d_address[31:2], 2'b00};
      byteenable_d = bus.d_byteenable;
      wait_cnt_d   = 32'd0;
      // a write wins over a simultaneous read
      if (bus.d_write) begin
        write_d     = 1'b1;
        read_d      = 1'b0;
        writedata_d = bus.d_writedata;
      end else begin
        write_d = 1'b0;
        read_d  = 1'b1;
      end
    end else if (complete || timeout) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      if (timeout) begin
        bus_error_d = 1'b1;
      end else begin
        bus_error_d = bus_error_q;
      end
      // an aborted transfer returns zero instead of bus data
      if (state_q == BUSY_I) begin
        i_ack_d      = 1'b1;
        i_readdata_d = timeout ? 32'h0000_0000 : bus.readdata;
      end else begin
        d_ack_d = 1'b1;
        if (read_q) begin
          d_readdata_d = timeout ? 32'h0000_0000 : bus.readdata;
        end else begin
          d_readdata_d = d_readdata_q;
        end
      end
    end else if (busy && bus.waitrequest) begin
      wait_cnt_d = wait_inc;
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // State and output registers; reset drops the strobes immediately and discards any transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_D;
      wait_cnt_q   <= 32'd0;
      address_q    <= 32'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      i_readdata_q <= 32'd0;
      i_ack_q      <= 1'b0;
      d_readdata_q <= 32'd0;
      d_ack_q      <= 1'b0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_cnt_q   <= wait_cnt_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      i_readdata_q <= i_readdata_d;
      i_ack_q      <= i_ack_d;
      d_readdata_q <= d_readdata_d;
      d_ack_q      <= d_ack_d;
      bus_error_q  <= bus_error_d;
    end
  end

  assign bus.address    = address_q;
  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.writedata  = writedata_q;
  assign bus.byteenable = byteenable_q;
  assign bus.i_readdata = i_readdata_q;
  assign bus.i_ack      = i_ack_q;
  assign bus.d_readdata = d_readdata_q;
  assign bus.d_ack      = d_ack_q;
  assign bus.bus_error  = bus_error_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Self-checking bench for mips_mem_arbiter: a transaction-level model of the
// arbiter is compared with the DUT every cycle, plus directed literal checks.
module tb_mips_mem_arbiter;
  localparam int MW = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mips_mem_arbiter_if ifc ();

  mips_mem_arbiter #(.MAX_WAIT(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- memory slave ----------------
  int          stall_left = 0;
  bit          stall_forever = 1'b0;
  logic [31:0] rd_value = 32'h0;

  always @(negedge clk) begin
    ifc.readdata = rd_value;
    if ((ifc.read || ifc.write) && (stall_forever || stall_left > 0)) begin
      ifc.waitrequest = 1'b1;
      if (stall_left > 0) stall_left--;
    end else begin
      ifc.waitrequest = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  int          owner = -1;   // -1 nobody, 0 fetch port, 1 data port
  bit          last_was_d = 1'b1;
  int          stalls = 0;
  bit          prev_i, prev_d, want_i, want_d;
  logic [31:0] fin_data;
  logic [31:0] e_address = 32'h0, e_wdata = 32'h0, e_i_rdata = 32'h0, e_d_rdata = 32'h0;
  logic [3:0]  e_be = 4'h0;
  logic        e_read = 1'b0, e_write = 1'b0, e_i_ack = 1'b0, e_d_ack = 1'b0, e_err = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      owner = -1; last_was_d = 1'b1; stalls = 0;
      e_address = 32'h0; e_wdata = 32'h0; e_i_rdata = 32'h0; e_d_rdata = 32'h0;
      e_be = 4'h0; e_read = 1'b0; e_write = 1'b0; e_i_ack = 1'b0; e_d_ack = 1'b0; e_err = 1'b0;
    end else begin
      prev_i = e_i_ack;
      prev_d = e_d_ack;
      e_i_ack = 1'b0;
      e_d_ack = 1'b0;
      if (owner < 0) begin
        want_i = ifc.i_read && !prev_i;
        want_d = (ifc.d_read || ifc.d_write) && !prev_d;
        if (want_i && (!want_d || last_was_d)) begin
          owner = 0; last_was_d = 1'b0; stalls = 0;
          e_address = ifc.i_address & 32'hFFFF_FFFC;
          e_read = 1'b1; e_write = 1'b0; e_be = 4'hF;
        end else if (want_d) begin
          owner = 1; last_was_d = 1'b1; stalls = 0;
          e_address = ifc.d_address & 32'hFFFF_FFFC;
          e_be = ifc.d_byteenable;
          if (ifc.d_write) begin
            e_write = 1'b1; e_read = 1'b0; e_wdata = ifc.d_writedata;
          end else begin
            e_write = 1'b0; e_read = 1'b1;
          end
        end
      end else if (!ifc.waitrequest || (stalls + 1 >= MW)) begin
        fin_data = ifc.waitrequest ? 32'h0 : ifc.readdata;
        if (ifc.waitrequest) e_err = 1'b1;
        if (owner == 0) begin
          e_i_ack = 1'b1; e_i_rdata = fin_data;
        end else begin
          e_d_ack = 1'b1;
          if (e_read) e_d_rdata = fin_data;
        end
        e_read = 1'b0; e_write = 1'b0; owner = -1;
      end else begin
        stalls++;
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_address", ifc.address, e_address);
      chk("cmp_ctl", {ifc.read, ifc.write, ifc.byteenable, ifc.i_ack, ifc.d_ack, ifc.bus_error},
          {e_read, e_write, e_be, e_i_ack, e_d_ack, e_err});
      chk("cmp_writedata", ifc.writedata, e_wdata);
      chk("cmp_i_readdata", ifc.i_readdata, e_i_rdata);
      chk("cmp_d_readdata", ifc.d_readdata, e_d_rdata);
    end
  end

  // ---------------- bus monitor ----------------
  int          n_rd = 0, n_wr = 0, n_iack = 0, n_dack = 0;
  int          order[$];
  logic [31:0] wr_addr = 32'h0, wr_data = 32'h0, rd_addr = 32'h0;
  logic [3:0]  wr_be = 4'h0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.read) begin n_rd++; rd_addr = ifc.address; end
      if (ifc.write) begin n_wr++; wr_addr = ifc.address; wr_data = ifc.writedata; wr_be = ifc.byteenable; end
      if (ifc.i_ack) begin n_iack++; order.push_back(0); end
      if (ifc.d_ack) begin n_dack++; order.push_back(1); end
    end
  end

  task automatic clear_mon();
    n_rd = 0; n_wr = 0; n_iack = 0; n_dack = 0;
    order.delete();
  endtask

  function automatic int order_at(input int k);
    if (k < order.size()) return order[k];
    return -1;
  endfunction

  // Hold requests until acked; drop each just after the edge that ends its ack cycle
  task automatic serve(input int need_i, input int need_d, input string tag);
    int got_i = 0;
    int got_d = 0;
    bit si, sd;
    for (int c = 0; c < 60 && (got_i < need_i || got_d < need_d); c++) begin
      @(negedge clk);
      si = ifc.i_ack;
      sd = ifc.d_ack;
      @(posedge clk);
      #1;
      if (si) begin got_i++; ifc.i_read = 1'b0; end
      if (sd) begin got_d++; ifc.d_read = 1'b0; ifc.d_write = 1'b0; end
    end
    chk({tag, "_iacks"}, got_i, need_i);
    chk({tag, "_dacks"}, got_d, need_d);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    ifc.i_read = 1'b0; ifc.i_address = 32'h0;
    ifc.d_read = 1'b0; ifc.d_write = 1'b0; ifc.d_address = 32'h0;
    ifc.d_writedata = 32'h0; ifc.d_byteenable = 4'h0;
    ifc.waitrequest = 1'b0; ifc.readdata = 32'h0;

    // reset values, checked while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", {ifc.address, ifc.writedata}, 64'h0);
    chk("rst_ctl", {ifc.read, ifc.write, ifc.byteenable, ifc.i_ack, ifc.d_ack, ifc.bus_error}, 64'h0);
    chk("rst_rdata", {ifc.i_readdata, ifc.d_readdata}, 64'h0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single zero-wait fetch
    clear_mon();
    ifc.i_read = 1'b1; ifc.i_address = 32'hBFC0_0000; rd_value = 32'h2402_0005;
    @(negedge clk);
    chk("t1_idle_read", ifc.read, 1'b0);
    @(negedge clk);
    chk("t1_strobe", {ifc.read, ifc.write, ifc.byteenable, ifc.i_ack}, {1'b1, 1'b0, 4'hF, 1'b0});
    chk("t1_address", ifc.address, 32'hBFC0_0000);
    @(negedge clk);
    chk("t1_ack", {ifc.i_ack, ifc.read}, {1'b1, 1'b0});
    chk("t1_rdata", ifc.i_readdata, 32'h2402_0005);
    @(posedge clk); #1 ifc.i_read = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_bus_reads", n_rd, 1);
    chk("t1_acks", n_iack, 1);

    // 2: stalled write, unaligned address
    @(posedge clk); #1;
    clear_mon();
    stall_left = 3;
    ifc.d_write = 1'b1; ifc.d_address = 32'h0000_1006; ifc.d_byteenable = 4'b1100;
    ifc.d_writedata = 32'hDEAD_BEEF;
    serve(0, 1, "t2");
    repeat (2) @(negedge clk);
    chk("t2_write_cycles", n_wr, 4);
    chk("t2_wr_addr", wr_addr, 32'h0000_1004);
    chk("t2_wr_data_be", {wr_data, wr_be}, {32'hDEAD_BEEF, 4'b1100});
    chk("t2_dacks", n_dack, 1);

    // 3: simultaneous requests, round-robin order
    @(posedge clk); #1;
    clear_mon();
    rd_value = 32'h1111_2222;
    ifc.i_read = 1'b1; ifc.i_address = 32'h0000_0400;
    ifc.d_read = 1'b1; ifc.d_address = 32'h0000_0803; ifc.d_byteenable = 4'b0011;
    serve(1, 1, "t3a");
    repeat (3) @(negedge clk);
    chk("t3a_first", order_at(0), 0);
    chk("t3a_second", order_at(1), 1);
    chk("t3a_once", {n_iack[7:0], n_dack[7:0], order.size()}, {8'd1, 8'd1, 32'd2});
    @(posedge clk); #1;
    ifc.i_read = 1'b1; ifc.i_address = 32'h0000_0500;
    serve(1, 0, "t3b");
    @(posedge clk); #1;
    clear_mon();
    ifc.i_read = 1'b1; ifc.i_address = 32'h0000_0600;
    ifc.d_read = 1'b1; ifc.d_address = 32'h0000_0900;
    serve(1, 1, "t3c");
    repeat (3) @(negedge clk);
    chk("t3c_first", order_at(0), 1);
    chk("t3c_second", order_at(1), 0);

    // 6: read and write together -> write only, load data untouched
    @(posedge clk); #1;
    clear_mon();
    rd_value = 32'h9999_9999;
    ifc.d_read = 1'b1; ifc.d_write = 1'b1; ifc.d_address = 32'h0000_2008;
    ifc.d_writedata = 32'h0BAD_F00D; ifc.d_byteenable = 4'b1111;
    serve(0, 1, "t6");
    repeat (2) @(negedge clk);
    chk("t6_no_read", n_rd, 0);
    chk("t6_one_write", n_wr, 1);
    chk("t6_wr", {wr_addr, wr_data}, {32'h0000_2008, 32'h0BAD_F00D});
    chk("t6_d_readdata", ifc.d_readdata, 32'h1111_2222);

    // 4: asynchronous reset in the middle of a stalled write
    @(posedge clk); #1;
    clear_mon();
    stall_left = 100;
    ifc.d_write = 1'b1; ifc.d_address = 32'h0000_3000; ifc.d_writedata = 32'h1234_5678;
    ifc.d_byteenable = 4'hF;
    @(posedge clk);            // grant
    @(posedge clk);            // first stalled edge
    #1 chk("t4_write_before", ifc.write, 1'b1);
    #1 reset = 1'b1;
    #1 chk("t4_write_async_drop", {ifc.write, ifc.read}, 2'b00);
    ifc.d_write = 1'b0;
    stall_left = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_zero_bus", {ifc.address, ifc.writedata}, 64'h0);
    chk("t4_zero_ctl", {ifc.read, ifc.write, ifc.byteenable, ifc.i_ack, ifc.d_ack, ifc.bus_error}, 64'h0);
    chk("t4_zero_rdata", {ifc.i_readdata, ifc.d_readdata}, 64'h0);
    chk("t4_no_ack", n_dack + n_iack, 0);

    // 5: watchdog abort, then normal fetch
    @(posedge clk); #1;
    clear_mon();
    stall_forever = 1'b1;
    rd_value = 32'hCAFE_F00D;
    ifc.d_read = 1'b1; ifc.d_address = 32'h0000_4000; ifc.d_byteenable = 4'hF;
    serve(0, 1, "t5a");
    stall_forever = 1'b0;
    chk("t5_read_cycles", n_rd, 4);
    chk("t5_d_readdata", ifc.d_readdata, 32'h0);
    chk("t5_bus_error", ifc.bus_error, 1'b1);
    ifc.i_read = 1'b1; ifc.i_address = 32'h0000_0104;
    serve(1, 0, "t5b");
    @(negedge clk);
    chk("t5_fetch_data", ifc.i_readdata, 32'hCAFE_F00D);
    chk("t5_error_sticky", ifc.bus_error, 1'b1);
    chk("t5_fetch_addr", rd_addr, 32'h0000_0104);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
Shares one single-ported, wait-request memory bus between the CPU's instruction-fetch port and data port, for the bus-interface build of the MIPS CPU. Each requester holds a request until it receives a one-cycle ack with registered read data. Simultaneous requests are arbitrated round-robin. A watchdog flags a stuck bus.

Parameters:
MAX_WAIT, 0, maximum consecutive cycles waitrequest may stay high during one transaction; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
i_read  in  1  instruction fetch request; held until i_ack
i_address  in  32  fetch byte address
i_readdata  out  32  fetched word; valid while i_ack=1
i_ack  out  1  one-cycle completion pulse for a fetch
d_read  in  1  data read request; held until d_ack
d_write  in  1  data write request; held until d_ack
d_address  in  32  data byte address
d_writedata  in  32  store data
d_byteenable  in  4  store/load byte lanes
d_readdata  out  32  load word; valid while d_ack=1
d_ack  out  1  one-cycle completion pulse for a data access
address  out  32  bus word address; bits[1:0] always 0
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  32  bus write data
byteenable  out  4  bus byte lanes
waitrequest  in  1  slave stall
readdata  in  32  bus read data; valid at the completing edge
bus_error  out  1  sticky watchdog flag

Behaviour:
- All outputs are registered. Reset (async) forces: state=IDLE, read=write=0, address=0, writedata=0, byteenable=0, i_ack=d_ack=0, i_readdata=d_readdata=0, bus_error=0, wait counter=0, last_grant=DATA.
- An in-flight transaction is discarded on reset. Strobes drop in the same cycle that reset asserts, with no waiting for a clock edge.
- States: IDLE, BUSY_I, BUSY_D.
- Eligibility in IDLE:
  - i is eligible if i_read=1 and i_ack=0.
  - d is eligible if (d_read|d_write)=1 and d_ack=0.
  - The ack-mask prevents re-granting a requester in the cycle it is being acked.
- Grant rule in IDLE:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester that is not last_grant.
  - Update last_grant on every grant.
- Grant to instruction port: go to BUSY_I. Next cycle drive address={i_address[31:2],2'b00}, read=1, write=0, byteenable=4'b1111.
- Grant to data port: go to BUSY_D. Next cycle drive address={d_address[31:2],2'b00}, byteenable=d_byteenable.
  - d_write=1: write=1, read=0, writedata=d_writedata.
  - d_read=1 and d_write=0: read=1.
  - d_read and d_write both high: the write takes precedence and the read is ignored.
- Address, strobes, writedata and byteenable are held stable while waitrequest=1.
- Completion occurs at the rising edge where the state is BUSY_x, a strobe is high, and waitrequest=0. At that edge:
  - readdata is captured into i_readdata or d_readdata (d_readdata is left unchanged for writes).
  - The matching ack goes high for exactly one cycle.
  - Strobes drop to 0 and the state returns to IDLE.
- Latency with zero wait states: request seen at edge N, strobe high during cycle N+1, ack high during cycle N+2. Minimum 2 cycles per transaction; back-to-back transactions at 3-cycle spacing.
- i_readdata and d_readdata hold their value after the ack until the next completion on that port.
- Requests presented while BUSY are queued implicitly: the requester keeps asserting and is considered at the next IDLE.
- Watchdog (MAX_WAIT>0):
  - The counter increments each BUSY cycle with waitrequest=1 and clears on grant.
  - When the counter reaches MAX_WAIT: set bus_error=1, drop strobes, issue the pending ack with readdata=32'h0, and return to IDLE.
  - bus_error is sticky until reset. Arbitration continues normally afterwards.
- Requesters must not change address or data while their request is pending. Violations give undefined results and are not checked.

Test Plan:
1. Reset, then i_read=1, i_address=32'hBFC00000, waitrequest=0, readdata=32'h24020005 -> read=1, address=BFC00000, byteenable=F in cycle 1; i_ack=1 and i_readdata=24020005 in cycle 2; exactly one bus read.
2. d_write=1, d_address=32'h00001006, d_byteenable=4'b1100, d_writedata=32'hDEADBEEF, waitrequest high 3 cycles -> address=00001004, write=1 held 4 cycles, signals stable; d_ack exactly once, the cycle after waitrequest falls.
3. i_read and d_read asserted together from reset -> instruction granted first (last_grant=DATA), then data; second simultaneous pair -> the other port goes first; no requester is granted twice without being re-asserted.
4. Assert reset while write=1 and waitrequest=1 -> write drops asynchronously before the next edge; no ack issued; after release the state is IDLE and all outputs are 0.
5. MAX_WAIT=4, d_read pending, waitrequest held high -> after 4 stalled cycles read=0, d_ack=1 with d_readdata=0, bus_error=1 and staying 1; a following i_read completes normally.
6. d_read=1 and d_write=1 together -> a bus write occurs with read=0 throughout; d_readdata unchanged.
